// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: T-state control sequencer for the single-bus datapath; MULDIV_EN adds MUL/DIV with LO/HI writeback.
// Start taken only while ready; ALU ops done 4 cycles after start, MUL 5, DIV 5+DIV_WAIT; every output is a flop.
module alu_op_sequencer #(
  parameter int NREG     = 16,
  parameter int OPW      = 4,
  parameter int DIV_WAIT = 2
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            start,
  input  logic [OPW-1:0]  opcode,
  input  logic [3:0]      ra,
  input  logic [3:0]      rb,
  input  logic [3:0]      rc,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [NREG-1:0] reg_out,
  output logic [NREG-1:0] reg_in,
  output logic            Yin,
  output logic            Zhighin,
  output logic            Zlowin,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            HIin,
  output logic            LOin,
  output logic [OPW-1:0]  alu_op
);

  if (DIV_WAIT < 0 || DIV_WAIT > 7) begin : g_div_wait_range
    $error("DIV_WAIT must be in 0..7");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_DONE, S_ERR
  } state_t;

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_MUL = OPW'(5);
  localparam logic [OPW-1:0] OP_DIV = OPW'(6);

  function automatic logic is_legal(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b1;
`ifdef MULDIV_EN
      OP_MUL, OP_DIV: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [OPW-1:0] opc_q, opc_d;
  logic [3:0]     ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic           is_md_q, is_md_d;
  logic           z_go_d;

  logic            ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [NREG-1:0] reg_out_q, reg_out_d, reg_in_q, reg_in_d;
  logic            yin_q, yin_d, zin_q, zin_d, zlo_out_q, zlo_out_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;

`ifdef MULDIV_EN
  localparam logic [2:0] DIV_LAST = 3'(DIV_WAIT);
  logic [2:0] cnt_q, cnt_d;
  logic       lo_in_q, lo_in_d, hi_in_q, hi_in_d;

  assign is_md_q = (opc_q == OP_MUL) || (opc_q == OP_DIV);
  assign is_md_d = (opc_d == OP_MUL) || (opc_d == OP_DIV);
  // Z loads only on the last DIV stall cycle, after the divider has settled.
  assign z_go_d  = !((opc_d == OP_DIV) && (cnt_d != DIV_LAST));
`else
  assign is_md_q = 1'b0;
  assign is_md_d = 1'b0;
  assign z_go_d  = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
`ifdef MULDIV_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opc_d   = opcode;
          ra_d    = ra;
          rb_d    = rb;
          rc_d    = rc;
          state_d = is_legal(opcode) ? S_T0 : S_ERR;
        end
      end
      S_T0: begin
        state_d = S_T1;
`ifdef MULDIV_EN
        cnt_d   = 3'd0;
`endif
      end
      S_T1: begin
`ifdef MULDIV_EN
        if ((opc_q == OP_DIV) && (cnt_q != DIV_LAST)) cnt_d = cnt_q + 3'd1;
        else                                          state_d = S_T2;
`else
        state_d = S_T2;
`endif
      end
      S_T2:    state_d = is_md_q ? S_T3 : S_DONE;
      S_T3:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the flops line up with the state they describe.
  always_comb begin
    ready_d   = (state_d == S_IDLE);
    busy_d    = (state_d == S_T0) || (state_d == S_T1) || (state_d == S_T2) ||
                (state_d == S_T3) || (state_d == S_DONE);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
    reg_out_d = '0;
    reg_in_d  = '0;
    yin_d     = (state_d == S_T0);
    zin_d     = (state_d == S_T1) && z_go_d;
    zlo_out_d = (state_d == S_T2);
    alu_op_d  = busy_d ? opc_d : '0;
    if (state_d == S_T0) reg_out_d[rb_d] = 1'b1;
    if (state_d == S_T1) reg_out_d[rc_d] = 1'b1;
    if ((state_d == S_T2) && !is_md_d) reg_in_d[ra_d] = 1'b1;
`ifdef MULDIV_EN
    lo_in_d   = (state_d == S_T2) && is_md_d;
    hi_in_d   = (state_d == S_T3);
`endif
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      opc_q     <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      reg_out_q <= '0;
      reg_in_q  <= '0;
      yin_q     <= 1'b0;
      zin_q     <= 1'b0;
      zlo_out_q <= 1'b0;
      alu_op_q  <= '0;
`ifdef MULDIV_EN
      cnt_q     <= '0;
      lo_in_q   <= 1'b0;
      hi_in_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      reg_out_q <= reg_out_d;
      reg_in_q  <= reg_in_d;
      yin_q     <= yin_d;
      zin_q     <= zin_d;
      zlo_out_q <= zlo_out_d;
      alu_op_q  <= alu_op_d;
`ifdef MULDIV_EN
      cnt_q     <= cnt_d;
      lo_in_q   <= lo_in_d;
      hi_in_q   <= hi_in_d;
`endif
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign reg_out = reg_out_q;
  assign reg_in  = reg_in_q;
  assign Yin     = yin_q;
  assign Zhighin = zin_q;
  assign Zlowin  = zin_q;
  assign Zlowout = zlo_out_q;
  assign alu_op  = alu_op_q;
`ifdef MULDIV_EN
  assign LOin     = lo_in_q;
  assign HIin     = hi_in_q;
  assign Zhighout = hi_in_q;
`else
  assign LOin     = 1'b0;
  assign HIin     = 1'b0;
  assign Zhighout = 1'b0;
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control-step sequencer for the 32-bit single-bus datapath (R0-R15, HI, LO, Y, Zhigh/Zlow, bus mux, ALU).
- Accepts one register-register ALU instruction (opcode, Ra, Rb, Rc) per start handshake.
- Emits the per-cycle register out/in strobes and the ALU op code, moving operands over the bus through Y and Z, then writing the result back.
- Sits between the instruction source (testbench now, later the decode unit) and the datapath control inputs.

Parameters:
- NREG, 16, number of general registers; width of the one-hot select buses.
- OPW, 4, opcode and alu_op width.
- DIV_WAIT, 2, extra T1 cycles held for DIV before Z is loaded (0..7).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- start  in  1  instruction valid; accepted only when ready=1.
- opcode  in  OPW  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 5 MUL (with MULDIV_EN), 6 DIV (with MULDIV_EN); all others illegal.
- ra, rb, rc  in  4 each  destination and source register indices.
- ready  out  1  idle and able to accept start.
- busy  out  1  instruction in progress.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse on illegal opcode.
- reg_out  out  NREG  one-hot R0out..R15out.
- reg_in  out  NREG  one-hot R0in..R15in.
- Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin  out  1 each  datapath strobes.
- alu_op  out  OPW  latched opcode driven to the ALU.

Behaviour:
- Reset: state=IDLE, fields cleared, ready=1, all other outputs 0, alu_op=0. Clear wins over every other input in the same cycle. Clear mid-instruction aborts it: no further strobes and no done.
- All outputs decode from registered state and fields only; no input-to-output combinational path.
- IDLE: ready=1. When start=1, latch opcode/ra/rb/rc. Go to ERR if the opcode is illegal, otherwise T0. The start level is ignored outside IDLE.
- T0: reg_out[rb]=1, Yin=1.
- T1: reg_out[rc]=1, alu_op valid.
  - Non-DIV: Zhighin=Zlowin=1 in the single T1 cycle.
  - DIV: 3-bit counter holds T1 for DIV_WAIT+1 cycles, with reg_out[rc] and alu_op stable throughout. Zhighin/Zlowin assert only on the final cycle.
- T2: Zlowout=1. For ADD/SUB/AND/OR, reg_in[ra]=1 and the next state is DONE. For MUL/DIV, LOin=1 and the next state is T3.
- T3 (MUL/DIV only): Zhighout=1, HIin=1, then DONE.
- DONE: done=1 for one cycle, then IDLE. ready=0 in DONE, so the minimum start-to-start spacing is 5 cycles for ALU ops.
- ERR: err=1 for one cycle, then IDLE. No reg_in, Yin, Z, HI or LO strobe during an illegal instruction.
- alu_op holds the latched opcode from T0 through DONE and is 0 in IDLE and ERR.
- busy=1 in T0..T3 and DONE.
- Invariant: at most one bus driver (reg_out bit, Zhighout, Zlowout) per cycle; at most one reg_in bit per cycle.
- Latency, start sampled in cycle N:
  - ALU ops: T0=N+1, T1=N+2, T2=N+3, done at N+4.
  - MUL: done at N+5.
  - DIV: done at N+5+DIV_WAIT.
- Operand aliasing (ra=rb, rb=rc, all equal) needs no special handling. The source is read in T0/T1 and the destination written in T2.

Optional Feature:
- Macro MULDIV_EN.
- Defined: opcodes 5/6 legal with the T2(LO)/T3(HI) writeback and the DIV_WAIT stall.
- Undefined: opcodes 5/6 take the ERR path, the T3 state and wait counter are not built, and HIin/LOin/Zhighout are tied to 0.

Test Plan:
- Reset mid-op: clear asserted during T1 of an ADD -> next cycle IDLE, ready=1, all strobes 0, no done, R-file unchanged.
- ADD: R2=7, R3=5, start ADD ra=1 rb=2 rc=3 -> R2out+Yin at N+1, R3out+Zin at N+2, Zlowout+R1in at N+3, done at N+4, R1=12.
- SUB: R4=3, R5=10, SUB ra=4 rb=4 rc=5 -> R4=0xFFFFFFF9, done at N+4. A start held high through DONE is accepted only on return to IDLE.
- MUL (MULDIV_EN): R6=0x10000, R7=0x10000 -> LO=0 at N+3, HI=1 at N+4, done at N+5, no reg_in asserted.
- DIV with DIV_WAIT=2 (MULDIV_EN): R8=17, R9=5 -> T1 held 3 cycles with Zin only on the last, LO=3, HI=2, done at N+7.
- Illegal opcode 0xF (and 5 without MULDIV_EN) -> err at N+1, no done, no Yin/Z/reg_in strobes, ready at N+2.
